jtkcpu_stack_seq: RTL and testbench

Parametrised push/pull sequencer that walks a register-select mask and issues one byte-wide memory cycle per register byte. It is the successor to the fixed 8-register push/pull logic inside the register file, and adds a configurable register count and per-register width, a req/ack memory handshake with wait states, and an explicit stack-pointer output. It sits between the instruction control unit, the register file (read mux and write strobes) and the bus interface.

---
 rtl/jtkcpu_stack_seq_pkg.sv | 14 +
 rtl/jtkcpu_stack_seq_prio_sel.sv | 24 ++
 rtl/jtkcpu_stack_seq.sv | 123 ++++++++++++
 tb/tb_jtkcpu_stack_seq.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/jtkcpu_stack_seq_pkg.sv
// Shared definitions for the push/pull stack sequencer: FSM encoding and the
// default wide-register layout of the CPU register file.
package jtkcpu_stack_seq_pkg;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_XFER = 2'd1,
    SEQ_DONE = 2'd2
  } seq_st_t;

  // Registers 4..7 are the 16-bit ones in the CPU layout.
  localparam logic [15:0] SEQ_WIDE_DEF = 16'h00F0;

endpackage

// File: rtl/jtkcpu_stack_seq_prio_sel.sv
// Priority finder: index of the lowest (i_low=1) or highest set bit of i_vec.
module jtkcpu_prio_sel #(
  parameter int NREG = 8
) (
  input  logic [NREG-1:0] i_vec,
  input  logic            i_low,
  output logic [3:0]      o_idx,
  output logic            o_found
);

  always_comb begin
    o_idx   = '0;
    o_found = |i_vec;
    // Later hits overwrite earlier ones, so scan order picks the winner.
    if (i_low) begin
      for (int i = NREG - 1; i >= 0; i--)
        if (i_vec[i]) o_idx = 4'(i);
    end else begin
      for (int i = 0; i < NREG; i++)
        if (i_vec[i]) o_idx = 4'(i);
    end
  end

endmodule

// File: rtl/jtkcpu_stack_seq.sv
// Push/pull sequencer: walks a register mask and issues one byte-wide memory
// cycle per register byte, with req/ack wait states and a running stack pointer.
module jtkcpu_stack_seq
  import jtkcpu_stack_seq_pkg::*;
#(
  parameter int          NREG = 8,
  parameter logic [15:0] WIDE = SEQ_WIDE_DEF,
  parameter int          AW   = 16
) (
  input  logic            rst,
  input  logic            clk,
  input  logic            cen,
  input  logic            start,
  input  logic            pull,
  input  logic [NREG-1:0] sel,
  input  logic [AW-1:0]   sp_in,
  output logic [3:0]      reg_idx,
  input  logic [15:0]     reg_din,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [7:0]      mem_dout,
  input  logic [7:0]      mem_din,
  input  logic            mem_ack,
  output logic            wr_en,
  output logic            wr_hi,
  output logic [7:0]      wr_data,
  output logic [AW-1:0]   sp_out,
  output logic            busy,
  output logic            done
);

  seq_st_t         r_st, w_st_nxt;
  logic [NREG-1:0] r_mask;
  logic            r_pull, r_sec;
  logic [AW-1:0]   r_sp;
  logic            r_wr_en, r_wr_hi;
  logic [7:0]      r_wr_data;
  logic [3:0]      r_widx;

  logic [3:0]      w_cur;
  logic            w_found, w_wide, w_hi, w_adv, w_reg_end, w_last;
  logic [NREG-1:0] w_mask_nxt;

  jtkcpu_prio_sel #(.NREG(NREG)) u_prio (
    .i_vec   (r_mask),
    .i_low   (r_pull),
    .o_idx   (w_cur),
    .o_found (w_found)
  );

  // r_sec marks the second byte of a wide register; push goes lo->hi, pull hi->lo.
  assign w_wide     = WIDE[w_cur];
  assign w_hi       = w_wide & (r_pull ? ~r_sec : r_sec);
  assign w_adv      = (r_st == SEQ_XFER) & mem_ack & w_found;
  assign w_reg_end  = ~w_wide | r_sec;
  assign w_mask_nxt = r_mask & ~(NREG'(1) << w_cur);
  assign w_last     = w_reg_end & (w_mask_nxt == '0);

  always_comb begin
    w_st_nxt = r_st;
    case (r_st)
      SEQ_IDLE: if (start) w_st_nxt = (sel == '0) ? SEQ_DONE : SEQ_XFER;
      SEQ_XFER: if (w_adv && w_last) w_st_nxt = SEQ_DONE;
      SEQ_DONE: w_st_nxt = SEQ_IDLE;
      default:  w_st_nxt = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_st <= SEQ_IDLE;
    else if (cen) r_st <= w_st_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mask    <= '0;
      r_pull    <= 1'b0;
      r_sec     <= 1'b0;
      r_sp      <= '0;
      r_wr_en   <= 1'b0;
      r_wr_hi   <= 1'b0;
      r_wr_data <= '0;
      r_widx    <= '0;
    end else if (cen) begin
      r_wr_en <= 1'b0;
      if (r_st == SEQ_IDLE && start) begin
        r_mask <= sel;
        r_pull <= pull;
        r_sp   <= sp_in;
        r_sec  <= 1'b0;
      end else if (w_adv) begin
        r_sp <= r_pull ? r_sp + AW'(1) : r_sp - AW'(1);
        if (w_reg_end) begin
          r_mask <= w_mask_nxt;
          r_sec  <= 1'b0;
        end else begin
          r_sec  <= 1'b1;
        end
        if (r_pull) begin
          r_wr_en   <= 1'b1;
          r_wr_hi   <= w_hi;
          r_wr_data <= mem_din;
          r_widx    <= w_cur;
        end
      end
    end
  end

  assign mem_req  = (r_st == SEQ_XFER);
  assign mem_we   = mem_req & ~r_pull;
  assign mem_addr = mem_req ? (r_pull ? r_sp : r_sp - AW'(1)) : '0;
  assign mem_dout = mem_we ? (w_hi ? reg_din[15:8] : reg_din[7:0]) : 8'h00;
  // Push needs the live register for the read mux; pull reports the write target.
  assign reg_idx  = mem_we ? w_cur : r_widx;
  assign wr_en    = r_wr_en;
  assign wr_hi    = r_wr_hi;
  assign wr_data  = r_wr_data;
  assign sp_out   = r_sp;
  assign busy     = (r_st != SEQ_IDLE);
  assign done     = (r_st == SEQ_DONE);

endmodule

// File: tb/tb_jtkcpu_stack_seq.sv
// Scoreboard bench for jtkcpu_stack_seq: a byte-list reference model fills
// expectation queues; a monitor checks memory cycles, write strobes and done.
module tb_jtkcpu_stack_seq;
  localparam int          NREG = 8;
  localparam logic [15:0] WIDE = 16'h00F0;

  logic        rst, clk, cen, start, pull;
  logic [7:0]  sel;
  logic [15:0] sp_in, reg_din, mem_addr, sp_out;
  logic [3:0]  reg_idx;
  logic        mem_req, mem_we, mem_ack, wr_en, wr_hi, busy, done;
  logic [7:0]  mem_dout, mem_din, wr_data;

  jtkcpu_stack_seq #(.NREG(NREG), .WIDE(WIDE), .AW(16)) dut (
    .rst(rst), .clk(clk), .cen(cen), .start(start), .pull(pull), .sel(sel),
    .sp_in(sp_in), .reg_idx(reg_idx), .reg_din(reg_din), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_din(mem_din),
    .mem_ack(mem_ack), .wr_en(wr_en), .wr_hi(wr_hi), .wr_data(wr_data),
    .sp_out(sp_out), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { bit we; logic [15:0] addr; logic [7:0] data; } mx_t;
  typedef struct { logic [3:0] idx; bit hi; logic [7:0] data; } wx_t;

  mx_t         exp_mem[$];
  wx_t         exp_wr[$];
  logic [15:0] exp_done[$];
  logic [7:0]  mem [int];
  logic [15:0] regs [16];
  int          errs = 0, checks = 0;
  int          fixed_wait = 0, wait_max = 0, req_cycles = 0;
  bit          junk_ack = 0;

  assign reg_din = regs[reg_idx];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference model: the byte sequence straight from the ordering rules.
  task automatic model(input bit p, input logic [7:0] s, input logic [15:0] sp);
    logic [15:0] a;
    logic [7:0]  b;
    a = sp;
    if (!p) begin
      for (int r = NREG - 1; r >= 0; r--) if (s[r]) begin
        a = a - 16'd1; exp_mem.push_back('{1'b1, a, regs[r][7:0]});
        if (WIDE[r]) begin a = a - 16'd1; exp_mem.push_back('{1'b1, a, regs[r][15:8]}); end
      end
    end else begin
      for (int r = 0; r < NREG; r++) if (s[r]) begin
        for (int h = (WIDE[r] ? 1 : 0); h >= 0; h--) begin
          if (!mem.exists(int'(a))) mem[int'(a)] = 8'($urandom);
          b = mem[int'(a)];
          exp_mem.push_back('{1'b0, a, b});
          exp_wr.push_back('{4'(r), bit'(h), b});
          a = a + 16'd1;
        end
      end
    end
    exp_done.push_back(a);
  endtask

  function automatic int pick_wait();
    return (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, wait_max));
  endfunction

  // Memory responder with configurable wait states and stray acks while idle.
  initial begin
    int cnt, tgt;
    cnt = 0; tgt = 0; mem_ack = 1'b0; mem_din = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst && cen && mem_req && mem_ack) begin
        if (mem_we) mem[int'(mem_addr)] = mem_dout;
        cnt = 0; tgt = pick_wait();
      end else if (!mem_req) begin
        cnt = 0; tgt = pick_wait();
      end else if (cen) cnt++;
      @(posedge clk); #1;
      if (mem_req) mem_ack = (cnt >= tgt);
      else mem_ack = junk_ack ? 1'($urandom_range(0, 1)) : 1'b0;
      mem_din = (mem_req && !mem_we && mem.exists(int'(mem_addr))) ? mem[int'(mem_addr)] : 8'h00;
    end
  end

  // Monitor / scoreboard.
  initial begin
    bit pend; logic [15:0] paddr; logic [8:0] pdat;
    mx_t m; wx_t w;
    pend = 0; paddr = '0; pdat = '0;
    forever begin
      @(negedge clk);
      if (rst) pend = 0;
      else begin
        if (mem_req) req_cycles++;
        if (pend && mem_req) begin
          chk("hold_addr", 32'(mem_addr), 32'(paddr));
          chk("hold_we_dout", 32'({mem_we, mem_dout}), 32'(pdat));
        end
        if (cen && mem_req && mem_ack) begin
          if (exp_mem.size() == 0) chk("unexpected_mem_cycle", 1, 0);
          else begin
            m = exp_mem.pop_front();
            chk("mem_we", 32'(mem_we), 32'(m.we));
            chk("mem_addr", 32'(mem_addr), 32'(m.addr));
            if (m.we) chk("mem_dout", 32'(mem_dout), 32'(m.data));
          end
        end
        if (cen && wr_en) begin
          if (exp_wr.size() == 0) chk("unexpected_wr_en", 1, 0);
          else begin
            w = exp_wr.pop_front();
            chk("wr_idx_hi_data", 32'({reg_idx, wr_hi, wr_data}), 32'({w.idx, w.hi, w.data}));
          end
          if (wr_hi) regs[reg_idx][15:8] = wr_data;
          else regs[reg_idx][7:0] = wr_data;
        end
        if (cen && done) begin
          if (exp_done.size() == 0) chk("unexpected_done", 1, 0);
          else begin
            chk("sp_out_final", 32'(sp_out), 32'(exp_done.pop_front()));
            chk("busy_with_done", 32'(busy), 1);
          end
        end
        pend  = mem_req && !(cen && mem_ack);
        paddr = mem_addr;
        pdat  = {mem_we, mem_dout};
      end
    end
  end

  // Issue one operation (called at posedge+1) and wait, bounded, for done.
  task automatic do_op(input bit p, input logic [7:0] s, input logic [15:0] sp,
                       input bit rnd, output int lat);
    bit got;
    model(p, s, sp);
    start = 1'b1; pull = p; sel = s; sp_in = sp; cen = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; sel = 8'($urandom); pull = 1'($urandom); sp_in = 16'($urandom);
    lat = 0; got = 0;
    for (int c = 0; c < 400 && !got; c++) begin
      cen = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (rnd) start = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      lat++;
      if (done && cen) got = 1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    chk("done_seen", 32'(got), 1);
    chk("mem_queue_drained", exp_mem.size(), 0);
    chk("wr_queue_drained", exp_wr.size(), 0);
    exp_mem.delete(); exp_wr.delete(); exp_done.delete();
  endtask

  initial begin
    int lat;
    rst = 1'b1; cen = 1'b1; start = 1'b0; pull = 1'b0; sel = '0; sp_in = '0;
    for (int i = 0; i < 16; i++) regs[i] = 16'($urandom);
    @(negedge clk);
    chk("reset_ctrl", 32'({mem_req, mem_we, wr_en, wr_hi, busy, done}), 0);
    chk("reset_sp_addr", 32'({sp_out, mem_addr}), 0);
    chk("reset_data_idx", 32'({mem_dout, wr_data, reg_idx}), 0);
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;

    fixed_wait = 0;
    regs[7] = 16'hABCD; regs[0] = 16'h775A;
    do_op(0, 8'h81, 16'h1000, 0, lat);
    chk("push_latency", lat, 4);
    chk("push_mem_0fff", 32'(mem[32'h0FFF]), 32'hCD);
    chk("push_mem_0ffe", 32'(mem[32'h0FFE]), 32'hAB);
    chk("push_mem_0ffd", 32'(mem[32'h0FFD]), 32'h5A);

    regs[7] = 16'h0000; regs[0] = 16'h7700;
    do_op(1, 8'h81, 16'h0FFD, 0, lat);
    chk("pull_reg0", 32'(regs[0]), 32'h775A);
    chk("pull_reg7", 32'(regs[7]), 32'hABCD);
    chk("pull_latency", lat, 4);

    fixed_wait = 3; regs[1] = 16'h9933; req_cycles = 0;
    do_op(0, 8'h02, 16'h2000, 0, lat);
    chk("wait_req_cycles", req_cycles, 4);
    chk("wait_mem_1fff", 32'(mem[32'h1FFF]), 32'h33);

    fixed_wait = 0; req_cycles = 0;
    do_op(0, 8'h00, 16'h1234, 0, lat);
    chk("empty_latency", lat, 1);
    chk("empty_no_req", req_cycles, 0);

    do_op(1, 8'h10, 16'hFFFF, 0, lat);

    // Abort a 3-byte push right after its first byte.
    model(0, 8'h81, 16'h3000);
    start = 1'b1; pull = 1'b0; sel = 8'h81; sp_in = 16'h3000;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    chk("abort_bytes_left", exp_mem.size(), 2);
    exp_mem.delete(); exp_wr.delete(); exp_done.delete();
    @(negedge clk);
    chk("abort_state", 32'({mem_req, busy, done, sp_out}), 0);
    @(posedge clk); #1; rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    do_op(0, 8'h81, 16'h3000, 0, lat);
    chk("after_abort_latency", lat, 4);

    fixed_wait = -1; wait_max = 3; junk_ack = 1;
    for (int k = 0; k < 40; k++) begin
      logic [15:0] sp;
      logic [7:0]  s;
      for (int i = 0; i < NREG; i++) if ($urandom_range(0, 1) == 0) regs[i] = 16'($urandom);
      s  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      sp = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 6)) - 16'd3 : 16'($urandom);
      do_op(1'($urandom), s, sp, 1, lat);
    end
    junk_ack = 0;
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
